// File: rtl/node_lane_array.sv
// node_lane_array: parametrised SIMD processing stripe.
// LANES fixed-point lanes share one configuration. Each lane captures
// tag-matched operand blocks from a broadcast bus and runs an ALU and
// accumulator iteration a configured number of times. The final
// accumulator values are presented on a valid/ready result port.
//
// Optional feature macro: NODE_LANE_SATURATE_EN. When it is defined, the
// result conversion clamps to the DATA_W signed range. When it is not
// defined, the conversion truncates and wraps.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   cfg_*             config handshake
//                     instr[1:0]: op (00 ADD, 01 SUB, 10 MUL, 11 ADD)
//                     instr[2]:   accumulate
//                     instr[3]:   scalar
//                     cfg_lane:   scalar source lane
//                     also tags, strides and iteration limit
//   in_*              operand broadcast bus (valid/ready, tag, LANES*DATA_W data)
//   out_*             result handshake (valid/ready, LANES*DATA_W data)
//   busy              high whenever the FSM is not idle
module node_lane_array #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned TAG_W  = 12,
  parameter int unsigned ACC_W  = 2*DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [3:0]                 cfg_instr,
  input  logic [$clog2(LANES)-1:0]   cfg_lane,
  input  logic [TAG_W-1:0]           cfg_tag_a,
  input  logic [TAG_W-1:0]           cfg_tag_b,
  input  logic [TAG_W-1:0]           cfg_stride_a,
  input  logic [TAG_W-1:0]           cfg_stride_b,
  input  logic [TAG_W-1:0]           cfg_iter_lim,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [LANES*DATA_W-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic                       busy
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned PW = 2*DATA_W;
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC_W-1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EXEC, ST_DRAIN} state_t;

  state_t                        state_q, state_d;
  logic [1:0]                    op_q, op_d;
  logic                          accum_q, accum_d;
  logic                          scalar_q, scalar_d;
  logic [LW-1:0]                 lane_q, lane_d;
  logic [TAG_W-1:0]              tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic [TAG_W-1:0]              stride_a_q, stride_a_d, stride_b_q, stride_b_d;
  logic [TAG_W-1:0]              lim_q, lim_d, iter_q, iter_d;
  logic                          flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic [LANES*DATA_W-1:0]       opa_q, opa_d, opb_q, opb_d;
  logic [LANES-1:0][ACC_W-1:0]   acc_q, acc_d;

  logic [LANES-1:0][ACC_W-1:0]   acc_nxt;
  logic signed [DATA_W-1:0]      a_s, b_s;
  logic signed [PW-1:0]          prod_s, f_s;
  logic [TAG_W-1:0]              iter_inc;

  // Per-lane ALU. Sums are formed at 2*DATA_W so they never overflow
  // before reaching the accumulator.
  always_comb begin
    acc_nxt = '0;
    a_s     = '0;
    b_s     = '0;
    prod_s  = '0;
    f_s     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_s    = scalar_q ? opa_q[32'(lane_q)*DATA_W +: DATA_W] : opa_q[i*DATA_W +: DATA_W];
      b_s    = opb_q[i*DATA_W +: DATA_W];
      prod_s = PW'(a_s) * PW'(b_s);
      case (op_q)
        2'b01:   f_s = PW'(a_s) - PW'(b_s);
        2'b10:   f_s = (prod_s + RND) >>> FRAC_W;
        default: f_s = PW'(a_s) + PW'(b_s);
      endcase
      acc_nxt[i] = accum_q ? (acc_q[i] + ACC_W'(f_s)) : ACC_W'(f_s);
    end
  end

  assign iter_inc = iter_q + TAG_W'(1);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    accum_d    = accum_q;
    scalar_d   = scalar_q;
    lane_d     = lane_q;
    tag_a_d    = tag_a_q;
    tag_b_d    = tag_b_q;
    stride_a_d = stride_a_q;
    stride_b_d = stride_b_q;
    lim_d      = lim_q;
    iter_d     = iter_q;
    flag_a_d   = flag_a_q;
    flag_b_d   = flag_b_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          op_d       = cfg_instr[1:0];
          accum_d    = cfg_instr[2];
          scalar_d   = cfg_instr[3];
          lane_d     = cfg_lane;
          tag_a_d    = cfg_tag_a;
          tag_b_d    = cfg_tag_b;
          stride_a_d = cfg_stride_a;
          stride_b_d = cfg_stride_b;
          lim_d      = cfg_iter_lim;
          iter_d     = '0;
          flag_a_d   = 1'b0;
          flag_b_d   = 1'b0;
          acc_d      = '0;
          state_d    = (cfg_iter_lim == '0) ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // One beat may fill both operands when the two tags coincide.
        if (in_valid) begin
          if (in_tag == tag_a_q && !flag_a_q) begin
            opa_d    = in_data;
            flag_a_d = 1'b1;
          end
          if (in_tag == tag_b_q && !flag_b_q) begin
            opb_d    = in_data;
            flag_b_d = 1'b1;
          end
        end
        if (flag_a_d && flag_b_d) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        acc_d    = acc_nxt;
        tag_a_d  = tag_a_q + stride_a_q;
        tag_b_d  = tag_b_q + stride_b_q;
        iter_d   = iter_inc;
        flag_a_d = 1'b0;
        flag_b_d = 1'b0;
        state_d  = (iter_inc == lim_q) ? ST_DRAIN : ST_WAIT;
      end
      ST_DRAIN: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      accum_q    <= 1'b0;
      scalar_q   <= 1'b0;
      lane_q     <= '0;
      tag_a_q    <= '0;
      tag_b_q    <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      lim_q      <= '0;
      iter_q     <= '0;
      flag_a_q   <= 1'b0;
      flag_b_q   <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      accum_q    <= accum_d;
      scalar_q   <= scalar_d;
      lane_q     <= lane_d;
      tag_a_q    <= tag_a_d;
      tag_b_q    <= tag_b_d;
      stride_a_q <= stride_a_d;
      stride_b_q <= stride_b_d;
      lim_q      <= lim_d;
      iter_q     <= iter_d;
      flag_a_q   <= flag_a_d;
      flag_b_q   <= flag_b_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_WAIT);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q != ST_IDLE);

  // Result conversion works only on the registered accumulators, so the
  // result is stable for as long as DRAIN is held.
`ifdef NODE_LANE_SATURATE_EN
  localparam logic [DATA_W-1:0]        MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'(MAX_D);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ~SAT_MAX;

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if ($signed(acc_q[i]) > SAT_MAX)
        out_data[i*DATA_W +: DATA_W] = MAX_D;
      else if ($signed(acc_q[i]) < SAT_MIN)
        out_data[i*DATA_W +: DATA_W] = ~MAX_D;
      else
        out_data[i*DATA_W +: DATA_W] = acc_q[i][DATA_W-1:0];
    end
  end
`else
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      out_data[i*DATA_W +: DATA_W] = acc_q[i][DATA_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_node_lane_array.sv
module tb_node_lane_array;

  localparam int BW = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [3:0]      cfg_instr = '0;
  logic [2:0]      cfg_lane = '0;
  logic [11:0]     cfg_tag_a = '0, cfg_tag_b = '0;
  logic [11:0]     cfg_stride_a = '0, cfg_stride_b = '0, cfg_iter_lim = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [11:0]     in_tag = '0;
  logic [BW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BW-1:0]   out_data;
  logic            busy;

  int checks = 0;
  int failures = 0;

  node_lane_array #(.LANES(8), .DATA_W(16), .FRAC_W(8), .TAG_W(12), .ACC_W(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_instr(cfg_instr),
    .cfg_lane(cfg_lane), .cfg_tag_a(cfg_tag_a), .cfg_tag_b(cfg_tag_b),
    .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b),
    .cfg_iter_lim(cfg_iter_lim),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    instr;
    logic [2:0]    lane;
    logic [11:0]   ta, tb, sa, sb, lim;
    logic [BW-1:0] a, b, exp_d;
    bit            junk;
    int            hold;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [BW-1:0] rep(input logic [15:0] x);
    return {8{x}};
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [11:0] tag, input logic [BW-1:0] data);
    int n;
    in_valid = 1'b1;
    in_tag   = tag;
    in_data  = data;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("beat_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_cfg(input vec_t v);
    int n;
    cfg_valid    = 1'b1;
    cfg_instr    = v.instr;
    cfg_lane     = v.lane;
    cfg_tag_a    = v.ta;
    cfg_tag_b    = v.tb;
    cfg_stride_a = v.sa;
    cfg_stride_b = v.sb;
    cfg_iter_lim = v.lim;
    n = 0;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("cfg_timeout", 1, 0);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_drain {cfg_ready,busy,out_valid}", BW'({cfg_ready, busy, out_valid}), BW'(3'b100));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [11:0] ta_k, tb_k;
    string nm;
    send_cfg(v);
    if (v.lim == 0) begin
      chk($sformatf("v%0d lim0 {busy,in_ready,out_valid}", idx),
          BW'({busy, in_ready, out_valid}), BW'(3'b101));
    end else begin
      chk($sformatf("v%0d wait {busy,in_ready,out_valid}", idx),
          BW'({busy, in_ready, out_valid}), BW'(3'b110));
      for (int k = 0; k < int'(v.lim); k++) begin
        ta_k = v.ta + 12'(k) * v.sa;
        tb_k = v.tb + 12'(k) * v.sb;
        send_beat(ta_k, v.a);
        if (v.junk && k == 0) send_beat(12'h030, rep(16'hFFFF));
        if (v.ta != v.tb) send_beat(tb_k, v.b);
        if (k + 1 < int'(v.lim)) begin
          chk($sformatf("v%0d exec%0d {busy,in_ready,out_valid}", idx, k),
              BW'({busy, in_ready, out_valid}), BW'(3'b100));
        end
      end
      chk($sformatf("v%0d exec {busy,in_ready,out_valid}", idx),
          BW'({busy, in_ready, out_valid}), BW'(3'b100));
      tick();
      chk($sformatf("v%0d out_valid", idx), BW'(out_valid), BW'(1));
    end
    nm = $sformatf("v%0d out_data", idx);
    chk(nm, out_data, v.exp_d);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk($sformatf("v%0d hold%0d out_valid", idx, h), BW'(out_valid), BW'(1));
      chk($sformatf("v%0d hold%0d out_data", idx, h), out_data, v.exp_d);
    end
    release_out();
  endtask

  function automatic vec_t mk(input logic [3:0] instr, input logic [11:0] ta, input logic [11:0] tb,
                              input logic [11:0] st, input logic [11:0] lim,
                              input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    vec_t v;
    v.instr = instr; v.lane = 3'd0; v.ta = ta; v.tb = tb; v.sa = st; v.sb = st;
    v.lim = lim; v.a = rep(a); v.b = rep(b); v.exp_d = rep(e); v.junk = 1'b0; v.hold = 0;
    return v;
  endfunction

  initial begin
    logic [15:0] sat_exp;
    vec_t rv;
`ifdef NODE_LANE_SATURATE_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hC000;
`endif
    vecs[0]  = mk(4'b0100, 12'h010, 12'h020, 12'd1, 12'd3, 16'h0100, 16'h0080, 16'h0480);
    vecs[0].junk = 1'b1;
    vecs[1]  = mk(4'b0010, 12'h100, 12'h101, 12'd0, 12'd1, 16'h0180, 16'h0101, 16'h0182);
    vecs[2]  = mk(4'b0010, 12'h100, 12'h101, 12'd0, 12'd1, 16'h0180, 16'hFF00, 16'hFE80);
    vecs[3]  = mk(4'b0100, 12'h200, 12'h201, 12'd2, 12'd2, 16'h7000, 16'h7000, sat_exp);
    vecs[4]  = mk(4'b0000, 12'h000, 12'h000, 12'd0, 12'd0, 16'h0000, 16'h0000, 16'h0000);
    vecs[5]  = mk(4'b1010, 12'h300, 12'h301, 12'd1, 12'd1, 16'h0000, 16'h0000, 16'h0000);
    vecs[5].lane = 3'd3;
    for (int i = 0; i < 8; i++) begin
      vecs[5].a[i*16 +: 16]     = (i == 3) ? 16'h0200 : 16'h7FFF;
      vecs[5].b[i*16 +: 16]     = 16'(i * 16'h0100);
      vecs[5].exp_d[i*16 +: 16] = 16'(i * 16'h0200);
    end
    vecs[6]  = mk(4'b0001, 12'h055, 12'h055, 12'd1, 12'd1, 16'h0300, 16'h0300, 16'h0000);
    vecs[6].hold = 5;
    vecs[7]  = mk(4'b0001, 12'hFFF, 12'h000, 12'd1, 12'd2, 16'h0100, 16'h0300, 16'hFE00);
    vecs[8]  = mk(4'b0011, 12'h400, 12'h401, 12'd0, 12'd1, 16'h1234, 16'h0101, 16'h1335);
    vecs[9]  = mk(4'b0010, 12'h100, 12'h101, 12'd0, 12'd1, 16'hFF80, 16'h0080, 16'hFFC0);
    vecs[10] = mk(4'b0010, 12'h100, 12'h101, 12'd0, 12'd1, 16'h0001, 16'h0080, 16'h0001);
    vecs[11] = mk(4'b0010, 12'h100, 12'h101, 12'd0, 12'd1, 16'hFFFF, 16'h0080, 16'h0000);

    tick();
    tick();
    chk("reset {cfg_ready,in_ready,out_valid,busy}", BW'({cfg_ready, in_ready, out_valid, busy}), BW'(4'b1000));
    chk("reset out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset while waiting for B after A has been captured.
    rv = mk(4'b0000, 12'h010, 12'h020, 12'd1, 12'd1, 16'h0000, 16'h0000, 16'h0000);
    send_cfg(rv);
    send_beat(12'h010, rep(16'h0100));
    chk("pre_reset in_ready", BW'(in_ready), BW'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset {cfg_ready,in_ready,out_valid,busy}", BW'({cfg_ready, in_ready, out_valid, busy}), BW'(4'b1000));
    chk("async_reset out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    in_valid = 1'b1;
    in_tag   = 12'h020;
    in_data  = rep(16'h0080);
    tick();
    tick();
    in_valid = 1'b0;
    chk("post_reset idle {cfg_ready,busy,in_ready}", BW'({cfg_ready, busy, in_ready}), BW'(3'b100));
    send_cfg(rv);
    send_beat(12'h020, rep(16'h0080));
    tick();
    tick();
    tick();
    chk("post_reset A not retained {busy,in_ready,out_valid}", BW'({busy, in_ready, out_valid}), BW'(3'b110));
    send_beat(12'h010, rep(16'h0001));
    tick();
    chk("post_reset out_valid", BW'(out_valid), BW'(1));
    chk("post_reset out_data", out_data, rep(16'h0081));
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
